// File: rtl/job_seq_pkg.sv
// Shared definitions for the job_sequencer slice: FSM state encodings,
// error codes carried in the status byte, and status bit positions.
package job_seq_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_START_EARLY = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT     = 2'd2;
  localparam logic [1:0] ERR_START_BUSY  = 2'd3;

  localparam int STS_STATE_LSB = 0;
  localparam int STS_OVF       = 2;
  localparam int STS_UDF       = 3;
  localparam int STS_ERR_LSB   = 4;

  // Pack the WireOut status byte; bits [7:6] are always zero.
  function automatic logic [7:0] pack_status(input state_e st, input logic ovf,
                                             input logic udf, input logic [1:0] err);
    logic [7:0] s;
    s = 8'h00;
    s[STS_STATE_LSB +: 2] = st;
    s[STS_OVF]            = ovf;
    s[STS_UDF]            = udf;
    s[STS_ERR_LSB +: 2]   = err;
    return s;
  endfunction

endpackage

// File: rtl/job_in_stager.sv
// N_IN-word operand staging buffer for job_sequencer. Words are written in
// order at the write index; the full flag marks a complete operand set and
// blocks further writes until the controller rewinds the index.
module job_in_stager #(
  parameter int WORD_W = 32,
  parameter int N_IN   = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_clr,
  input  logic                     i_rewind,
  input  logic                     i_wr_en,
  input  logic [WORD_W-1:0]        i_wr_data,
  output logic [N_IN*WORD_W-1:0]   o_buf,
  output logic                     o_full,
  output logic                     o_wr_last
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [IDX_W-1:0]       r_wr_idx;
  logic [N_IN*WORD_W-1:0] r_buf;
  logic                   r_full;

  assign o_buf     = r_buf;
  assign o_full    = r_full;
  assign o_wr_last = i_wr_en && !r_full && (r_wr_idx == IDX_W'(N_IN - 1));

  // Write staging words in order; clear wipes contents, rewind only restarts the index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_idx <= '0;
      r_buf    <= '0;
      r_full   <= 1'b0;
    end else if (i_clr) begin
      r_wr_idx <= '0;
      r_buf    <= '0;
      r_full   <= 1'b0;
    end else if (i_rewind) begin
      r_wr_idx <= '0;
      r_full   <= 1'b0;
    end else if (i_wr_en && !r_full) begin
      for (int k = 0; k < N_IN; k++) begin
        if (r_wr_idx == IDX_W'(k)) begin
          r_buf[k*WORD_W +: WORD_W] <= i_wr_data;
        end
      end
      if (r_wr_idx == IDX_W'(N_IN - 1)) begin
        r_full <= 1'b1;
      end else begin
        r_wr_idx <= r_wr_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/job_sequencer.sv
// Host-side job controller for a start/done compute engine behind Opal Kelly
// endpoints (okClk domain). Stages N_IN pipe-in words, launches the engine on
// host_start, captures the result and serves N_OUT words to pipe-out.
// Optional feature macro: JOB_TIMEOUT_EN adds a BUSY watchdog of TIMEOUT_CYC
// cycles that aborts the job with error code TIMEOUT.
module job_sequencer
  import job_seq_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int N_IN        = 4,
  parameter int N_OUT       = 4,
  parameter int RES_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   soft_clr,
  input  logic                   host_start,
  input  logic [WORD_W-1:0]      pin_data,
  input  logic                   pin_valid,
  input  logic                   pout_read,
  output logic [WORD_W-1:0]      pout_data,
  output logic                   eng_start,
  output logic [N_IN*WORD_W-1:0] eng_din,
  input  logic                   eng_done,
  input  logic [RES_W-1:0]       eng_dout,
  output logic                   done_pulse,
  output logic                   err_pulse,
  output logic [7:0]             status
);

  localparam int RD_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int OUT_W = N_OUT * WORD_W;

  state_e             r_state;
  logic [RD_W-1:0]    r_rd_idx;
  logic [OUT_W-1:0]   r_out_buf;
  logic [WORD_W-1:0]  r_pout_data;
  logic               r_eng_start;
  logic               r_done_pulse;
  logic               r_err_pulse;
  logic               r_ovf;
  logic               r_udf;
  logic [1:0]         r_err;

`ifdef JOB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]   r_tmo;
`endif

  logic               w_wr_en;
  logic               w_wr_last;
  logic               w_full;
  logic               w_rd_last;
  logic               w_rewind;
  logic [OUT_W-1:0]   w_res_ext;
  logic [WORD_W-1:0]  w_next_word;

  assign w_wr_en   = pin_valid && (r_state == ST_LOAD) && !soft_clr;
  assign w_rd_last = (r_rd_idx == RD_W'(N_OUT - 1));
  assign w_rewind  = (r_state == ST_DRAIN) && pout_read && w_rd_last;

  job_in_stager #(
    .WORD_W (WORD_W),
    .N_IN   (N_IN)
  ) u_stager (
    .clk       (clk),
    .rstn      (rstn),
    .i_clr     (soft_clr),
    .i_rewind  (w_rewind),
    .i_wr_en   (w_wr_en),
    .i_wr_data (pin_data),
    .o_buf     (eng_din),
    .o_full    (w_full),
    .o_wr_last (w_wr_last)
  );

  // Zero-extend the engine result to the full output buffer width.
  always_comb begin
    w_res_ext              = '0;
    w_res_ext[RES_W-1:0]   = eng_dout;
  end

  // Select the word that follows the one currently presented on pipe-out.
  always_comb begin
    w_next_word = '0;
    for (int k = 1; k < N_OUT; k++) begin
      if (r_rd_idx == RD_W'(k - 1)) begin
        w_next_word = r_out_buf[k*WORD_W +: WORD_W];
      end else begin
        w_next_word = w_next_word;
      end
    end
  end

  // Controller FSM with registered pulses, pipe-out data and sticky status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_LOAD;
      r_rd_idx     <= '0;
      r_out_buf    <= '0;
      r_pout_data  <= '0;
      r_eng_start  <= 1'b0;
      r_done_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_err        <= ERR_NONE;
`ifdef JOB_TIMEOUT_EN
      r_tmo        <= '0;
`endif
    end else if (soft_clr) begin
      r_state      <= ST_LOAD;
      r_rd_idx     <= '0;
      r_out_buf    <= '0;
      r_pout_data  <= '0;
      r_eng_start  <= 1'b0;
      r_done_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_err        <= ERR_NONE;
`ifdef JOB_TIMEOUT_EN
      r_tmo        <= '0;
`endif
    end else begin
      r_eng_start  <= 1'b0;
      r_done_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;

      // Writes are only accepted while loading; anything else overflows.
      if (pin_valid && (r_state != ST_LOAD)) begin
        r_ovf <= 1'b1;
      end

      // Reads outside DRAIN underflow and return zero.
      if (pout_read && (r_state != ST_DRAIN)) begin
        r_pout_data <= '0;
        r_udf       <= 1'b1;
      end

      case (r_state)
        ST_LOAD: begin
          if (host_start) begin
            r_err       <= ERR_START_EARLY;
            r_err_pulse <= 1'b1;
          end
          if (w_wr_last) begin
            r_state <= ST_READY;
          end
        end

        ST_READY: begin
          if (host_start && w_full) begin
            r_eng_start <= 1'b1;
            r_state     <= ST_BUSY;
`ifdef JOB_TIMEOUT_EN
            r_tmo       <= '0;
`endif
          end
        end

        ST_BUSY: begin
          if (host_start) begin
            r_err       <= ERR_START_BUSY;
            r_err_pulse <= 1'b1;
          end
          // A done on the watchdog expiry cycle takes precedence over the timeout.
          if (eng_done) begin
            r_out_buf    <= w_res_ext;
            r_pout_data  <= w_res_ext[WORD_W-1:0];
            r_done_pulse <= 1'b1;
            r_rd_idx     <= '0;
            r_state      <= ST_DRAIN;
          end
`ifdef JOB_TIMEOUT_EN
          else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
            r_err       <= ERR_TIMEOUT;
            r_err_pulse <= 1'b1;
            r_out_buf   <= '0;
            r_pout_data <= '0;
            r_rd_idx    <= '0;
            r_state     <= ST_DRAIN;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
`endif
        end

        ST_DRAIN: begin
          if (host_start) begin
            r_err       <= ERR_START_BUSY;
            r_err_pulse <= 1'b1;
          end
          if (pout_read) begin
            if (w_rd_last) begin
              r_rd_idx    <= '0;
              r_pout_data <= '0;
              r_state     <= ST_LOAD;
            end else begin
              r_rd_idx    <= r_rd_idx + RD_W'(1);
              r_pout_data <= w_next_word;
            end
          end
        end

        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign pout_data  = r_pout_data;
  assign eng_start  = r_eng_start;
  assign done_pulse = r_done_pulse;
  assign err_pulse  = r_err_pulse;
  assign status     = pack_status(r_state, r_ovf, r_udf, r_err);

endmodule

// File: tb/tb_job_sequencer.sv
// Directed self-checking bench for job_sequencer (WORD_W=32, N_IN=N_OUT=4,
// RES_W=16, TIMEOUT_CYC=16). Timeout scenario runs when JOB_TIMEOUT_EN is set.
module tb_job_sequencer;

  logic         clk;
  logic         rstn;
  logic         soft_clr;
  logic         host_start;
  logic [31:0]  pin_data;
  logic         pin_valid;
  logic         pout_read;
  logic [31:0]  pout_data;
  logic         eng_start;
  logic [127:0] eng_din;
  logic         eng_done;
  logic [15:0]  eng_dout;
  logic         done_pulse;
  logic         err_pulse;
  logic [7:0]   status;

  int n_checks;
  int n_fail;

  job_sequencer #(
    .WORD_W      (32),
    .N_IN        (4),
    .N_OUT       (4),
    .RES_W       (16),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .soft_clr   (soft_clr),
    .host_start (host_start),
    .pin_data   (pin_data),
    .pin_valid  (pin_valid),
    .pout_read  (pout_read),
    .pout_data  (pout_data),
    .eng_start  (eng_start),
    .eng_din    (eng_din),
    .eng_done   (eng_done),
    .eng_dout   (eng_dout),
    .done_pulse (done_pulse),
    .err_pulse  (err_pulse),
    .status     (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w);
    pin_data  = w;
    pin_valid = 1'b1;
    tick();
    pin_valid = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [31:0] exp);
    check_eq(tag, pout_data, exp);
    pout_read = 1'b1;
    tick();
    pout_read = 1'b0;
  endtask

  task automatic engine_done(input logic [15:0] d);
    eng_dout = d;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic pulse_start();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
  endtask

  initial begin
    int errs;
    n_checks   = 0;
    n_fail     = 0;
    rstn       = 1'b0;
    soft_clr   = 1'b0;
    host_start = 1'b0;
    pin_data   = 32'h0;
    pin_valid  = 1'b0;
    pout_read  = 1'b0;
    eng_done   = 1'b0;
    eng_dout   = 16'h0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Reset state
    check_eq("rst_status", status, 8'h00);
    check_eq("rst_pout", pout_data, 32'h0);
    check_eq("rst_eng_start", eng_start, 1'b0);
    check_eq("rst_din", eng_din, 128'h0);

    // Basic job: four writes, start, engine result, four reads
    write_word(32'h1);
    write_word(32'h2);
    write_word(32'h3);
    check_eq("load_state", status[1:0], 2'd0);
    write_word(32'h4);
    check_eq("ready_state", status[1:0], 2'd1);
    pulse_start();
    check_eq("eng_start_hi", eng_start, 1'b1);
    check_eq("busy_state", status[1:0], 2'd2);
    check_eq("eng_din", eng_din, 128'h00000004_00000003_00000002_00000001);
    tick();
    check_eq("eng_start_lo", eng_start, 1'b0);
    engine_done(16'h000A);
    check_eq("done_pulse_hi", done_pulse, 1'b1);
    check_eq("drain_state", status[1:0], 2'd3);
    tick();
    check_eq("done_pulse_lo", done_pulse, 1'b0);
    read_word("rd0", 32'h0000000A);
    read_word("rd1", 32'h0);
    read_word("rd2", 32'h0);
    read_word("rd3", 32'h0);
    check_eq("job1_status", status, 8'h00);

    // Early start after two writes
    write_word(32'h10);
    write_word(32'h20);
    pulse_start();
    check_eq("early_err_pulse", err_pulse, 1'b1);
    check_eq("early_no_start", eng_start, 1'b0);
    check_eq("early_status", status, 8'h10);
    tick();
    check_eq("early_err_pulse_lo", err_pulse, 1'b0);
    write_word(32'h30);
    write_word(32'h40);
    pulse_start();
    check_eq("job2_start", eng_start, 1'b1);
    check_eq("job2_din", eng_din, 128'h00000040_00000030_00000020_00000010);
    engine_done(16'h1234);
    read_word("job2_rd0", 32'h00001234);
    read_word("job2_rd1", 32'h0);
    read_word("job2_rd2", 32'h0);
    read_word("job2_rd3", 32'h0);
    check_eq("job2_status", status, 8'h10);

    // Underflow in LOAD, overflow in READY, then soft clear
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    check_eq("clr_status0", status, 8'h00);
    read_word("udf_pre", 32'h0);
    check_eq("udf_pout", pout_data, 32'h0);
    check_eq("udf_status", status, 8'h08);
    write_word(32'h5);
    write_word(32'h6);
    write_word(32'h7);
    write_word(32'h8);
    write_word(32'h9);
    check_eq("ovf_status", status, 8'h0D);
    check_eq("ovf_din", eng_din, 128'h00000008_00000007_00000006_00000005);
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    check_eq("clr_status", status, 8'h00);
    check_eq("clr_din", eng_din, 128'h0);

    // Start on the same cycle as the last write is rejected
    write_word(32'hA);
    write_word(32'hB);
    write_word(32'hC);
    host_start = 1'b1;
    write_word(32'hD);
    host_start = 1'b0;
    check_eq("same_cyc_err_pulse", err_pulse, 1'b1);
    check_eq("same_cyc_no_start", eng_start, 1'b0);
    check_eq("same_cyc_status", status, 8'h11);
    check_eq("same_cyc_din", eng_din, 128'h0000000D_0000000C_0000000B_0000000A);
    pulse_start();
    check_eq("next_cyc_start", eng_start, 1'b1);
    pulse_start();
    check_eq("busy_err_pulse", err_pulse, 1'b1);
    check_eq("busy_err_status", status, 8'h32);
    engine_done(16'hBEEF);
    pulse_start();
    check_eq("drain_err_status", status, 8'h33);
    engine_done(16'h5555);
    check_eq("late_done_ignored", done_pulse, 1'b0);
    read_word("job4_rd0", 32'h0000BEEF);
    read_word("job4_rd1", 32'h0);
    read_word("job4_rd2", 32'h0);
    read_word("job4_rd3", 32'h0);
    engine_done(16'h7777);
    check_eq("done_in_load_ignored", done_pulse, 1'b0);

    // Watchdog behaviour
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    write_word(32'h1);
    write_word(32'h2);
    write_word(32'h3);
    write_word(32'h4);
    pulse_start();
`ifdef JOB_TIMEOUT_EN
    errs = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (err_pulse) errs++;
    end
    check_eq("tmo_no_early_err", errs, 0);
    tick();
    check_eq("tmo_err_pulse", err_pulse, 1'b1);
    check_eq("tmo_no_done", done_pulse, 1'b0);
    check_eq("tmo_status", status, 8'h23);
    engine_done(16'h00FF);
    check_eq("tmo_late_done", done_pulse, 1'b0);
    read_word("tmo_rd0", 32'h0);
    read_word("tmo_rd1", 32'h0);
    read_word("tmo_rd2", 32'h0);
    read_word("tmo_rd3", 32'h0);
    check_eq("tmo_end_status", status, 8'h20);
`else
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (err_pulse) errs++;
    end
    check_eq("wait_no_err", errs, 0);
    check_eq("wait_busy", status, 8'h02);
    engine_done(16'hFFFF);
    read_word("wait_rd0", 32'h0000FFFF);
    read_word("wait_rd1", 32'h0);
    read_word("wait_rd2", 32'h0);
    read_word("wait_rd3", 32'h0);
    check_eq("wait_end_status", status, 8'h00);
`endif

    // Asynchronous reset in the middle of BUSY
    write_word(32'h11);
    write_word(32'h22);
    write_word(32'h33);
    write_word(32'h44);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    check_eq("pre_rst_busy", status[1:0], 2'd2);
    rstn = 1'b0;
    #1;
    check_eq("arst_status", status, 8'h00);
    check_eq("arst_eng_start", eng_start, 1'b0);
    check_eq("arst_din", eng_din, 128'h0);
    check_eq("arst_pout", pout_data, 32'h0);
    check_eq("arst_pulses", {done_pulse, err_pulse}, 2'b00);
    tick();
    rstn = 1'b1;
    tick();
    write_word(32'h11);
    write_word(32'h22);
    write_word(32'h33);
    write_word(32'h44);
    pulse_start();
    check_eq("post_rst_start", eng_start, 1'b1);
    engine_done(16'h0055);
    check_eq("post_rst_done", done_pulse, 1'b1);
    read_word("post_rd0", 32'h00000055);
    read_word("post_rd1", 32'h0);
    read_word("post_rd2", 32'h0);
    read_word("post_rd3", 32'h0);
    check_eq("post_status", status, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
